// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared 32x16 memory port between instruction fetch (read-only) and execute (read/write).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise EX wins every tie.
module mem_port_arbiter #(
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          ex_req,
   input  logic          ex_we,
   input  logic [AW-1:0] ex_addr,
   input  logic [DW-1:0] ex_wdata,
   output logic          ex_gnt,
   output logic          ex_rvalid,
   output logic [DW-1:0] ex_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [7:0]    stall_cnt
);

   localparam logic [7:0] STALL_MAX = 8'hFF;

   logic if_elig;
   logic ex_elig;
   logic tie_ex;
   logic grant_if;
   logic grant_ex;
   logic lost;

`ifdef MEM_ARB_RR_EN
   logic last_ex;

   // Remembers which requester was granted most recently; resets to EX so IF wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_ex <= 1'b1;
      end else if (grant_if || grant_ex) begin
         last_ex <= grant_ex;
      end
   end

   always_comb begin
      tie_ex = ~last_ex;
   end
`else
   always_comb begin
      tie_ex = 1'b1;
   end
`endif

   // A request whose grant is showing this cycle has already been served.
   always_comb begin
      if_elig  = if_req & ~if_gnt;
      ex_elig  = ex_req & ~ex_gnt;
      grant_ex = ex_elig & (~if_elig | tie_ex);
      grant_if = if_elig & ~grant_ex;
      lost     = if_elig & ex_elig;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_gnt    <= 1'b0;
         ex_gnt    <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rvalid <= 1'b0;
         ex_rvalid <= 1'b0;
         stall_cnt <= '0;
      end else begin
         if_gnt <= grant_if;
         ex_gnt <= grant_ex;
         mem_en <= grant_if | grant_ex;
         mem_we <= grant_ex & ex_we;
         if (grant_ex) begin
            mem_addr  <= ex_addr;
            mem_wdata <= ex_wdata;
         end else if (grant_if) begin
            mem_addr <= if_addr;
         end
         // Read owner tag: the grant flags travel with the command one stage later.
         if_rvalid <= mem_en & ~mem_we & if_gnt;
         ex_rvalid <= mem_en & ~mem_we & ex_gnt;
         if (lost && (stall_cnt != STALL_MAX)) begin
            stall_cnt <= stall_cnt + 8'd1;
         end
      end
   end

   // Synchronous memory data is steered straight through to the owner.
   always_comb begin
      if_rdata = if_rvalid ? mem_rdata : '0;
      ex_rdata = ex_rvalid ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 32x16 synchronous memory.
// Expectations follow MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 16;

   logic          clk;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          ex_req;
   logic          ex_we;
   logic [AW-1:0] ex_addr;
   logic [DW-1:0] ex_wdata;
   logic          ex_gnt;
   logic          ex_rvalid;
   logic [DW-1:0] ex_rdata;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [7:0]    stall_cnt;

   logic [DW-1:0] mem [32];

   int n_checks = 0;
   int n_pass   = 0;

   mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .ex_req    (ex_req),
      .ex_we     (ex_we),
      .ex_addr   (ex_addr),
      .ex_wdata  (ex_wdata),
      .ex_gnt    (ex_gnt),
      .ex_rvalid (ex_rvalid),
      .ex_rdata  (ex_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents are not affected by the arbiter reset.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   typedef struct {
      logic          ir;
      logic [AW-1:0] ia;
      logic          er;
      logic          ew;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          e_ig;
      logic          e_eg;
      logic          e_en;
      logic          e_we;
      logic [AW-1:0] e_ad;
      logic [DW-1:0] e_wd;
      logic          e_irv;
      logic [DW-1:0] e_ird;
      logic          e_erv;
      logic [DW-1:0] e_erd;
      logic [7:0]    e_st;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic ir, logic [AW-1:0] ia, logic er, logic ew,
                               logic [AW-1:0] ea, logic [DW-1:0] ed,
                               logic e_ig, logic e_eg, logic e_en, logic e_we,
                               logic [AW-1:0] e_ad, logic [DW-1:0] e_wd,
                               logic e_irv, logic [DW-1:0] e_ird,
                               logic e_erv, logic [DW-1:0] e_erd, logic [7:0] e_st);
      vec_t v;
      v.ir = ir;  v.ia = ia;  v.er = er;  v.ew = ew;  v.ea = ea;  v.ed = ed;
      v.e_ig = e_ig;  v.e_eg = e_eg;  v.e_en = e_en;  v.e_we = e_we;
      v.e_ad = e_ad;  v.e_wd = e_wd;
      v.e_irv = e_irv;  v.e_ird = e_ird;  v.e_erv = e_erv;  v.e_erd = e_erd;
      v.e_st = e_st;
      return v;
   endfunction

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " if_gnt"},    32'(if_gnt),    0);
      check({tag, " ex_gnt"},    32'(ex_gnt),    0);
      check({tag, " mem_en"},    32'(mem_en),    0);
      check({tag, " mem_we"},    32'(mem_we),    0);
      check({tag, " mem_addr"},  32'(mem_addr),  0);
      check({tag, " mem_wdata"}, 32'(mem_wdata), 0);
      check({tag, " if_rvalid"}, 32'(if_rvalid), 0);
      check({tag, " if_rdata"},  32'(if_rdata),  0);
      check({tag, " ex_rvalid"}, 32'(ex_rvalid), 0);
      check({tag, " ex_rdata"},  32'(ex_rdata),  0);
      check({tag, " stall_cnt"}, 32'(stall_cnt), 0);
   endtask

   initial begin
      logic          if_first;
      logic          g_if;
      logic          prev_gif;
      logic [AW-1:0] last_ad;

      for (int a = 0; a < 32; a++) mem[a] = 16'(a * 3);
      mem[5] = 16'h04E8;
      mem[3] = 16'h1111;
      mem[9] = 16'h2222;
      mem_rdata = '0;

`ifdef MEM_ARB_RR_EN
      if_first = 1'b1;
`else
      if_first = 1'b0;
`endif

      // IF read, EX write, EX read-back.
      vq.push_back(mk(1, 5, 0, 0, 0, 0,            1, 0, 1, 0, 5, 0,            0, 0, 0, 0, 0));
      vq.push_back(mk(0, 5, 0, 0, 0, 0,            0, 0, 0, 0, 5, 0,            1, 16'h04E8, 0, 0, 0));
      vq.push_back(mk(0, 0, 1, 1, 7, 16'h6419,     0, 1, 1, 1, 7, 16'h6419,     0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 1, 7, 16'h6419,     0, 0, 0, 0, 7, 16'h6419,     0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 1, 0, 7, 16'h6419,     0, 1, 1, 0, 7, 16'h6419,     0, 0, 0, 0, 0));
      vq.push_back(mk(0, 0, 0, 0, 7, 16'h6419,     0, 0, 0, 0, 7, 16'h6419,     0, 0, 1, 16'h6419, 0));
      // Both held for 8 cycles: one tie at the start, then strict alternation.
      prev_gif = 1'b0;
      last_ad  = '0;
      for (int i = 0; i < 8; i++) begin
         g_if    = (((i % 2) == 0) == if_first);
         last_ad = g_if ? 5'd3 : 5'd9;
         vq.push_back(mk(1, 3, 1, 0, 9, 16'h6419,
                         g_if, !g_if, 1, 0, last_ad, 16'h6419,
                         (i > 0) && prev_gif,  ((i > 0) && prev_gif)  ? 16'h1111 : 16'h0,
                         (i > 0) && !prev_gif, ((i > 0) && !prev_gif) ? 16'h2222 : 16'h0,
                         1));
         prev_gif = g_if;
      end
      vq.push_back(mk(0, 3, 0, 0, 9, 16'h6419,    0, 0, 0, 0, last_ad, 16'h6419,
                      prev_gif, prev_gif ? 16'h1111 : 16'h0,
                      !prev_gif, !prev_gif ? 16'h2222 : 16'h0, 1));

      // Reset held with both requests up.
      rst = 1'b0;
      if_req = 1'b1;  if_addr = 5'd5;
      ex_req = 1'b1;  ex_we = 1'b0;  ex_addr = 5'd9;  ex_wdata = '0;
      #1;
      check_all_zero("reset_async");
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset_held");
      @(negedge clk);
      rst = 1'b1;
      if_req = 1'b0;
      ex_req = 1'b0;

      foreach (vq[i]) begin
         @(negedge clk);
         if_req = vq[i].ir;  if_addr = vq[i].ia;
         ex_req = vq[i].er;  ex_we = vq[i].ew;  ex_addr = vq[i].ea;  ex_wdata = vq[i].ed;
         @(posedge clk);
         #1;
         check($sformatf("v%0d if_gnt", i),    32'(if_gnt),    32'(vq[i].e_ig));
         check($sformatf("v%0d ex_gnt", i),    32'(ex_gnt),    32'(vq[i].e_eg));
         check($sformatf("v%0d mem_en", i),    32'(mem_en),    32'(vq[i].e_en));
         check($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(vq[i].e_we));
         check($sformatf("v%0d mem_addr", i),  32'(mem_addr),  32'(vq[i].e_ad));
         check($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(vq[i].e_wd));
         check($sformatf("v%0d if_rvalid", i), 32'(if_rvalid), 32'(vq[i].e_irv));
         check($sformatf("v%0d if_rdata", i),  32'(if_rdata),  32'(vq[i].e_ird));
         check($sformatf("v%0d ex_rvalid", i), 32'(ex_rvalid), 32'(vq[i].e_erv));
         check($sformatf("v%0d ex_rdata", i),  32'(ex_rdata),  32'(vq[i].e_erd));
         check($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vq[i].e_st));
      end

      // Reset between grant and read return: the return must never appear.
      @(negedge clk);
      if_req = 1'b1;  if_addr = 5'd5;
      @(posedge clk);
      #1;
      check("midrst if_gnt", 32'(if_gnt), 1);
      check("midrst mem_addr", 32'(mem_addr), 5);
      @(negedge clk);
      if_req = 1'b0;
      rst = 1'b0;
      #1;
      check_all_zero("midrst_async");
      @(posedge clk);
      #1;
      check("midrst if_rvalid_in_reset", 32'(if_rvalid), 0);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("midrst if_rvalid c%0d", c), 32'(if_rvalid), 0);
         check($sformatf("midrst if_rdata c%0d", c),  32'(if_rdata),  0);
         check($sformatf("midrst stall_cnt c%0d", c), 32'(stall_cnt), 0);
      end

      // Memory written before reset still holds its data.
      @(negedge clk);
      ex_req = 1'b1;  ex_we = 1'b0;  ex_addr = 5'd7;
      @(posedge clk);
      #1;
      check("postrst ex_gnt", 32'(ex_gnt), 1);
      @(negedge clk);
      ex_req = 1'b0;
      @(posedge clk);
      #1;
      check("postrst ex_rvalid", 32'(ex_rvalid), 1);
      check("postrst ex_rdata",  32'(ex_rdata),  32'h6419);
      check("postrst if_rvalid", 32'(if_rvalid), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single 32 x 16 unified memory port between the instruction-fetch unit (IF, read-only) and the execute unit (EX, read/write) of the CISC core. It sits between those two units and the memory block inside `cisc_top`, registers every memory command, and routes synchronous read data back to the requester that issued the read. It also keeps a saturating stall counter for performance debug.

## Interface
- `AW`, 5: memory address width.
- `DW`, 16: memory data width.

- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_req` in 1: IF read request; held with `if_addr` until `if_gnt`.
- `if_addr` in AW: IF read address.
- `if_gnt` out 1: one-cycle grant pulse to IF.
- `if_rvalid` out 1: IF read data valid.
- `if_rdata` out DW: IF read data.
- `ex_req` in 1: EX request; held with `ex_we`/`ex_addr`/`ex_wdata` until `ex_gnt`.
- `ex_we` in 1: 1 = write, 0 = read.
- `ex_addr` in AW: EX address.
- `ex_wdata` in DW: EX write data.
- `ex_gnt` out 1: one-cycle grant pulse to EX.
- `ex_rvalid` out 1: EX read data valid. Reads only.
- `ex_rdata` out DW: EX read data.
- `mem_en` out 1: memory access enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data. Valid the cycle after a read `mem_en`.
- `stall_cnt` out 8: saturating count of lost-arbitration cycles.

## Operation
- **Eligibility.** A requester is eligible at a rising edge when:
  - its `req` is high, and
  - its `gnt` is not high in the cycle that edge closes.

  A held request is therefore never double-granted. A requester drops `req`, or presents a new request, after seeing `gnt`.
- **Grant.** At each edge, at most one eligible requester is granted. The winner's command is registered:
  - `mem_en` = 1.
  - `mem_we` = `ex_we` for an EX grant, 0 for an IF grant.
  - `mem_addr` and `mem_wdata` (EX only) are registered from the winner.
  - The winner's `gnt` = 1.
- **Idle cycle.** With no grant, `mem_en`, `mem_we` and both `gnt` outputs are 0. `mem_addr` and `mem_wdata` hold their last values.
- **Read return.** A one-bit owner tag plus a read flag are pipelined one stage behind `mem_en`. In the cycle after a read command:
  - the owner's `rvalid` = 1;
  - the owner's `rdata` = `mem_rdata`, a combinational pass-through.
- **Write.** A write never produces `rvalid`. Non-asserted `rdata` outputs are driven to 0.
- **Stall counter.** `stall_cnt` increments by 1 on each edge where a requester was eligible but not granted. It saturates at 255.
- **Back-to-back traffic.** With both requesters held continuously, grants alternate IF, EX, IF, … and the port is used every cycle.

## Timing
- **Reset values.** All outputs are 0 while `rst` = 0, asynchronously. This includes `stall_cnt`, the pending read tag and `mem_addr`/`mem_wdata`. The round-robin pointer resets to "EX last", so IF wins the first tie.
- **Latency.** Request sampled at edge k:
  - `gnt` and the memory command are high for cycle k..k+1;
  - `rvalid` and `rdata` are valid for cycle k+1..k+2 (read);
  - the write commits at edge k+1.
- **Throughput.** Maximum one access per cycle total and one per two cycles per requester.
- **Reset mid-operation.** A pending `rvalid` is dropped and never reissued after reset. The memory content written before reset is unaffected.
- **Address width.** Addresses are exactly AW bits. There is no wrap or bounds logic in this block.

## Configuration
- Macro: `MEM_ARB_RR_EN`.
- **Defined.** Round-robin arbitration on a tie: the requester not granted most recently wins. The pointer updates on every grant.
- **Undefined.** Fixed priority, EX wins every tie. Because of the eligibility rule, IF is still granted at most one cycle later. The round-robin pointer is not implemented.

## Test plan
- **Reset.** Hold `rst` = 0 with `if_req` = `ex_req` = 1 → all outputs 0. Release → the first grant goes to IF in both configurations with one request pending; with `MEM_ARB_RR_EN` defined, IF also wins a tie.
- **Single IF read.**
  - Preload addr 5 = 16'h04E8. Pulse an IF read of addr 5.
  - Expect `if_gnt` and `mem_en` in the cycle after the sampling edge, `mem_we` = 0, `mem_addr` = 5.
  - Expect `if_rvalid` = 1 and `if_rdata` = 16'h04E8 one cycle later; `ex_rvalid` stays 0.
- **EX write then read.**
  - EX writes 16'h6419 to addr 7 → `mem_we` = 1 for one cycle, no `rvalid`.
  - EX then reads addr 7 → `ex_rvalid` with 16'h6419.
- **Tie arbitration, `MEM_ARB_RR_EN` defined.**
  - Both requesters held for 8 cycles → grants alternate IF, EX, … and `mem_en` stays 1 every cycle.
  - `stall_cnt` counts only the tie cycles.
- **Fixed priority, `MEM_ARB_RR_EN` undefined.**
  - First tie → EX granted.
  - IF granted the next cycle.
  - `stall_cnt` = 1 after that pair.
- **Async reset mid-read.** Drop `rst` between `if_gnt` and `if_rvalid` → `if_rvalid` never asserts, and `stall_cnt` = 0.
